// File: rtl/universal_shift_reg.sv
// WIDTH-bit universal register: hold, shift right/left, parallel load, sync clear, enable, shift counter.
// Define SHIFT_REG_ROTATE_EN to add the ROT input that turns shifts into rotates.
module universal_shift_reg #(
    parameter int   WIDTH = 8,
    localparam int  CNTW  = $clog2(WIDTH + 1)
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              EN,
    input  logic              CLR_n,
    input  logic [1:0]        MODE,
    input  logic [WIDTH-1:0]  D,
    input  logic              SI_R,
    input  logic              SI_L,
`ifdef SHIFT_REG_ROTATE_EN
    input  logic              ROT,
`endif
    output logic [WIDTH-1:0]  Q,
    output logic [WIDTH-1:0]  Q_n,
    output logic [CNTW-1:0]   CNT,
    output logic              DONE
);

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_RIGHT = 2'b01,
        MODE_LEFT  = 2'b10,
        MODE_LOAD  = 2'b11
    } mode_t;

    localparam logic [CNTW-1:0] CNT_MAX = CNTW'(WIDTH);

    logic [WIDTH-1:0] q_q, q_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             rightIn, leftIn;
    logic [CNTW-1:0]  cntInc;
    mode_t            mode;

    assign mode = mode_t'(MODE);

`ifdef SHIFT_REG_ROTATE_EN
    // Rotation feeds the bit falling off the far end back in, ignoring the serial inputs.
    assign rightIn = ROT ? q_q[0]       : SI_R;
    assign leftIn  = ROT ? q_q[WIDTH-1] : SI_L;
`else
    assign rightIn = SI_R;
    assign leftIn  = SI_L;
`endif

    assign cntInc = (cnt_q < CNT_MAX) ? cnt_q + 1'b1 : cnt_q;

    always_comb begin
        q_d   = q_q;
        cnt_d = cnt_q;
        if (!CLR_n) begin
            q_d   = '0;
            cnt_d = '0;
        end else if (EN) begin
            case (mode)
                MODE_HOLD: begin
                    q_d   = q_q;
                    cnt_d = cnt_q;
                end
                MODE_RIGHT: begin
                    q_d   = {rightIn, q_q[WIDTH-1:1]};
                    cnt_d = cntInc;
                end
                MODE_LEFT: begin
                    q_d   = {q_q[WIDTH-2:0], leftIn};
                    cnt_d = cntInc;
                end
                MODE_LOAD: begin
                    q_d   = D;
                    cnt_d = '0;
                end
                default: begin
                    q_d   = q_q;
                    cnt_d = cnt_q;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            q_q   <= '0;
            cnt_q <= '0;
        end else begin
            q_q   <= q_d;
            cnt_q <= cnt_d;
        end
    end

    // Outputs decode only registered state, so DONE has no path from the inputs.
    assign Q    = q_q;
    assign Q_n  = ~q_q;
    assign CNT  = cnt_q;
    assign DONE = (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_universal_shift_reg.sv
// Self-checking bench for universal_shift_reg (WIDTH=8) with a behavioural reference model.
module tb_universal_shift_reg;

    logic       CLK = 1'b0;
    logic       RST_n, EN, CLR_n, SI_R, SI_L;
    logic [1:0] MODE;
    logic [7:0] D;
    logic [7:0] Q, Q_n;
    logic [3:0] CNT;
    logic       DONE;
`ifdef SHIFT_REG_ROTATE_EN
    logic       ROT;
`endif

    int checks = 0;
    int errors = 0;
    int mQ;
    int mCnt;

    universal_shift_reg #(.WIDTH(8)) dut (
        .CLK(CLK), .RST_n(RST_n), .EN(EN), .CLR_n(CLR_n), .MODE(MODE),
        .D(D), .SI_R(SI_R), .SI_L(SI_L),
`ifdef SHIFT_REG_ROTATE_EN
        .ROT(ROT),
`endif
        .Q(Q), .Q_n(Q_n), .CNT(CNT), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    // Reference model: register as an integer 0..255, shifts as multiply/divide by two.
    task automatic applyStimulus;
        int inR, inL;
        inR = SI_R;
        inL = SI_L;
`ifdef SHIFT_REG_ROTATE_EN
        if (ROT) begin
            inR = mQ % 2;
            inL = mQ / 128;
        end
`endif
        if (!CLR_n) begin
            mQ = 0;
            mCnt = 0;
        end else if (EN) begin
            if (MODE == 2'd1) begin
                mQ = mQ / 2 + inR * 128;
                if (mCnt < 8) mCnt = mCnt + 1;
            end else if (MODE == 2'd2) begin
                mQ = (mQ * 2) % 256 + inL;
                if (mCnt < 8) mCnt = mCnt + 1;
            end else if (MODE == 2'd3) begin
                mQ = D;
                mCnt = 0;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic idleInputs;
        EN = 1'b1; CLR_n = 1'b1; MODE = 2'd0; D = 8'h00; SI_R = 1'b0; SI_L = 1'b0;
`ifdef SHIFT_REG_ROTATE_EN
        ROT = 1'b0;
`endif
    endtask

    task automatic test_reset;
        idleInputs();
        RST_n = 1'b1;
        mQ = 0; mCnt = 0;
        MODE = 2'd3; D = 8'h5A;
        applyStimulus();
        MODE = 2'd1;
        applyStimulus();
        RST_n = 1'b0;
        #2;
        checks++;
        if ({Q, Q_n, CNT, DONE} !== {8'h00, 8'hFF, 4'd0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_async: Q=%h Q_n=%h CNT=%0d DONE=%b, want 00 ff 0 0", Q, Q_n, CNT, DONE);
        end
        mQ = 0; mCnt = 0;
        @(posedge CLK); #1;
        RST_n = 1'b1;
        MODE = 2'd0;
    endtask

    task automatic test_load_shift_right;
        MODE = 2'd3; D = 8'hA5;
        applyStimulus();
        checks++;
        if ({Q, CNT} !== {8'hA5, 4'd0}) begin
            errors++;
            $display("[TB] FAIL load_a5: Q=%h CNT=%0d, want a5 0", Q, CNT);
        end
        MODE = 2'd1; SI_R = 1'b0;
        applyStimulus();
        checks++;
        if ({Q, Q_n, CNT} !== {8'h52, 8'hAD, 4'd1}) begin
            errors++;
            $display("[TB] FAIL shift_right: Q=%h Q_n=%h CNT=%0d, want 52 ad 1", Q, Q_n, CNT);
        end
    endtask

    task automatic test_shift_left_enable;
        MODE = 2'd3; D = 8'hA5;
        applyStimulus();
        MODE = 2'd2; SI_L = 1'b1;
        applyStimulus();
        checks++;
        if ({Q, CNT} !== {8'h4B, 4'd1}) begin
            errors++;
            $display("[TB] FAIL shift_left: Q=%h CNT=%0d, want 4b 1", Q, CNT);
        end
        EN = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus();
        checks++;
        if ({Q, CNT} !== {8'h4B, 4'd1}) begin
            errors++;
            $display("[TB] FAIL enable_hold: Q=%h CNT=%0d, want 4b 1", Q, CNT);
        end
        EN = 1'b1; SI_L = 1'b0;
    endtask

    task automatic test_saturate;
        MODE = 2'd3; D = 8'hFF;
        applyStimulus();
        MODE = 2'd1; SI_R = 1'b0;
        for (int i = 0; i < 7; i++) applyStimulus();
        checks++;
        if ({CNT, DONE} !== {4'd7, 1'b0}) begin
            errors++;
            $display("[TB] FAIL pre_done: CNT=%0d DONE=%b, want 7 0", CNT, DONE);
        end
        applyStimulus();
        checks++;
        if ({Q, CNT, DONE} !== {8'h00, 4'd8, 1'b1}) begin
            errors++;
            $display("[TB] FAIL serialise_done: Q=%h CNT=%0d DONE=%b, want 00 8 1", Q, CNT, DONE);
        end
        SI_R = 1'b1;
        applyStimulus();
        checks++;
        if ({Q, CNT, DONE} !== {8'h80, 4'd8, 1'b1}) begin
            errors++;
            $display("[TB] FAIL saturate: Q=%h CNT=%0d DONE=%b, want 80 8 1", Q, CNT, DONE);
        end
        MODE = 2'd3; D = 8'h3C;
        applyStimulus();
        checks++;
        if ({Q, CNT, DONE} !== {8'h3C, 4'd0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL load_after_done: Q=%h CNT=%0d DONE=%b, want 3c 0 0", Q, CNT, DONE);
        end
        SI_R = 1'b0;
    endtask

    task automatic test_clear_priority;
        CLR_n = 1'b0; MODE = 2'd3; D = 8'h77; EN = 1'b0;
        #2;
        checks++;
        if (Q !== 8'h3C) begin
            errors++;
            $display("[TB] FAIL clear_before_edge: Q=%h, want 3c", Q);
        end
        applyStimulus();
        checks++;
        if ({Q, CNT} !== {8'h00, 4'd0}) begin
            errors++;
            $display("[TB] FAIL clear_priority: Q=%h CNT=%0d, want 00 0", Q, CNT);
        end
        CLR_n = 1'b1; EN = 1'b1;
        MODE = 2'd3; D = 8'hC3;
        applyStimulus();
        MODE = 2'd2; SI_L = 1'b1;
        for (int i = 0; i < 5; i++) applyStimulus();
        checks++;
        if ({Q, CNT} !== {8'h7F, 4'd5}) begin
            errors++;
            $display("[TB] FAIL five_shifts: Q=%h CNT=%0d, want 7f 5", Q, CNT);
        end
        RST_n = 1'b0;
        #2;
        checks++;
        if ({Q, CNT, DONE} !== {8'h00, 4'd0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_mid_seq: Q=%h CNT=%0d DONE=%b, want 00 0 0", Q, CNT, DONE);
        end
        mQ = 0; mCnt = 0;
        @(posedge CLK); #1;
        RST_n = 1'b1;
        // First edge after release performs the sampled shift from zero.
        applyStimulus();
        checks++;
        if ({Q, CNT} !== {8'h01, 4'd1}) begin
            errors++;
            $display("[TB] FAIL after_reset_shift: Q=%h CNT=%0d, want 01 1", Q, CNT);
        end
        SI_L = 1'b0;
    endtask

`ifdef SHIFT_REG_ROTATE_EN
    task automatic test_rotate;
        MODE = 2'd3; D = 8'h81;
        applyStimulus();
        ROT = 1'b1; MODE = 2'd1; SI_R = 1'b0;
        applyStimulus();
        checks++;
        if (Q !== 8'hC0) begin
            errors++;
            $display("[TB] FAIL rotate_right: Q=%h, want c0", Q);
        end
        MODE = 2'd2; SI_L = 1'b0;
        applyStimulus();
        checks++;
        if ({Q, CNT} !== {8'h81, 4'd2}) begin
            errors++;
            $display("[TB] FAIL rotate_left: Q=%h CNT=%0d, want 81 2", Q, CNT);
        end
        ROT = 1'b0;
    endtask
`endif

    task automatic test_random;
        logic [7:0] expQ;
        logic [3:0] expCnt;
        for (int i = 0; i < 400; i++) begin
            EN    = ($urandom_range(0, 7) != 0);
            CLR_n = ($urandom_range(0, 15) != 0);
            MODE  = ($urandom_range(0, 5) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            D     = 8'($urandom);
            SI_R  = 1'($urandom);
            SI_L  = 1'($urandom);
`ifdef SHIFT_REG_ROTATE_EN
            ROT   = 1'($urandom);
`endif
            applyStimulus();
            expQ   = 8'(mQ);
            expCnt = 4'(mCnt);
            checks++;
            if ({Q, Q_n, CNT, DONE} !== {expQ, ~expQ, expCnt, (mCnt == 8)}) begin
                errors++;
                $display("[TB] FAIL random_%0d: Q=%h Q_n=%h CNT=%0d DONE=%b, want %h %h %0d %b",
                         i, Q, Q_n, CNT, DONE, expQ, ~expQ, expCnt, (mCnt == 8));
            end
        end
        idleInputs();
    endtask

    initial begin
        RST_n = 1'b0;
        idleInputs();
        #12;
        test_reset();
        test_load_shift_right();
        test_shift_left_enable();
        test_saturate();
        test_clear_priority();
`ifdef SHIFT_REG_ROTATE_EN
        test_rotate();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/universal_shift_reg.md
# universal_shift_reg

Parametrised universal register that extends the team's single-bit synchronous D flip-flop to a WIDTH-bit word with hold, shift-right, shift-left and parallel-load modes, a synchronous clear, a clock enable and complementary outputs. It also counts shifts since the last load, so it can act directly as a parallel-to-serial / serial-to-parallel converter in the lab datapath designs. It sits between switch/bus inputs and display or serial-link logic.

## Interface
- WIDTH, 8, register width in bits; legal range ≥2.
- CNTW, $clog2(WIDTH+1), width of the shift counter; derived, not to be overridden.
- CLK  input  1  rising-edge clock; the block's only clock.
- RST_n  input  1  asynchronous, active-low reset.
- EN  input  1  clock enable; 0 holds all state.
- CLR_n  input  1  synchronous active-low clear.
- MODE  input  2  operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- D  input  WIDTH  parallel load data.
- SI_R  input  1  serial input entering Q[WIDTH-1] on a right shift.
- SI_L  input  1  serial input entering Q[0] on a left shift.
- Q  output  WIDTH  register contents.
- Q_n  output  WIDTH  bitwise complement of Q.
- CNT  output  CNTW  number of shifts since last load or clear; saturates at WIDTH.
- DONE  output  1  high when CNT == WIDTH.

## Operation
- Priority, highest first: RST_n low (asynchronous), then CLR_n low, then EN low, then MODE.
- RST_n low: Q=0, CNT=0 immediately, independent of CLK. Outputs are then Q_n all ones and DONE=0.
- CLR_n low at a rising edge: Q=0 and CNT=0, regardless of EN and MODE.
- EN low: Q and CNT hold.
- MODE 00: hold Q and CNT.
- MODE 01: Q <= {SI_R, Q[WIDTH-1:1]}. CNT <= CNT+1 if CNT < WIDTH, otherwise CNT holds.
- MODE 10: Q <= {Q[WIDTH-2:0], SI_L}. CNT increments under the same saturating rule.
- MODE 11: Q <= D and CNT <= 0.
- Serial-out taps are Q[0] for right shifts and Q[WIDTH-1] for left shifts. They are read from Q; there are no separate ports.
- Q_n is driven combinationally as ~Q. It is never stored separately, so Q and Q_n are always exact complements.
- DONE is decoded combinationally from registered CNT and has no glitch path from the inputs.
- CNT never wraps. A shift issued while CNT == WIDTH still moves Q, and CNT stays at WIDTH.

## Timing
- Every function except reset has 1-cycle latency. The new Q, Q_n, CNT and DONE are visible after the rising edge at which the inputs were sampled.
- Reset is asynchronous on assertion. Deassertion is taken as-is; the integrating top synchronises RST_n release.
- Reset asserted mid-operation aborts any shift sequence. The first edge after release performs the sampled MODE from the zero state.
- CLR_n and a load in the same cycle: the clear wins, giving Q=0.
- DONE rises in the same cycle that CNT reaches WIDTH. It falls on the load, clear or reset edge that zeroes CNT.
- All inputs need setup/hold around the rising edge of CLK only. There are no multicycle paths.

## Configuration
- SHIFT_REG_ROTATE_EN defined:
  - adds input port ROT (1 bit);
  - when ROT=1, MODE 01 rotates right (Q[0] enters the MSB) and MODE 10 rotates left (Q[WIDTH-1] enters the LSB);
  - SI_R and SI_L are ignored while ROT=1;
  - CNT counts rotates exactly as it counts shifts.
- Not defined: ROT does not exist and shifts always take SI_R/SI_L.

## Test plan
- Reset: RST_n=0 between clock edges → Q=0x00, Q_n=0xFF, CNT=0, DONE=0 before the next edge.
- Load then shift right (WIDTH=8): MODE=11, D=0xA5 → Q=0xA5, CNT=0. Then MODE=01, SI_R=0 for 1 edge → Q=0x52, Q_n=0xAD, CNT=1.
- Shift left: from Q=0xA5, MODE=10, SI_L=1 → Q=0x4B, CNT=1. EN=0 for 3 edges → Q=0x4B, CNT=1 unchanged.
- Serialise/saturate: load 0xFF, then 8 right shifts with SI_R=0 → Q=0x00, CNT=8, DONE=1. A 9th shift → CNT=8, DONE=1. A load of 0x3C → CNT=0, DONE=0.
- Clear priority: CLR_n=0, MODE=11, D=0x77, EN=0 → Q=0x00 after the edge, no change before it. Then RST_n=0 mid-sequence at CNT=5 → CNT=0 immediately.
- Rotate (SHIFT_REG_ROTATE_EN): load 0x81, ROT=1, MODE=01, SI_R=0 → Q=0xC0. Then MODE=10 → Q=0x81, CNT=2.
